// File: rtl/sha256_pkg.sv
// Shared SHA-256 padding types, constants and block-count helper.
package sha256_pkg;

  typedef logic [511:0] sha256_block_t;

  typedef enum logic [1:0] {IDLE, FILL, PRESENT, DONE} pad_state_e;

  localparam logic [31:0] SHA256_PAD_MARKER = 32'h8000_0000;

  // Blocks needed for n message words plus marker and 2 length words.
  function automatic logic [15:0] sha256_num_blocks(input logic [15:0] n);
    logic [16:0] t;
    t = 17'(n) + 17'd2;
    return 16'(t >> 4) + 16'd1;
  endfunction

endpackage

// File: rtl/sha256_pad_word_sel.sv
// Combinational choice of one padded word at global index g.
// SHA256_PAD_BYTESWAP_EN byte-reverses memory words; marker/length words untouched.
module sha256_pad_word_sel
  import sha256_pkg::*;
(
  input  logic [15:0] g_i,
  input  logic [15:0] n_i,
  input  logic [7:0]  b_i,
  input  logic [7:0]  nblk_i,
  input  logic [3:0]  p_i,
  input  logic [31:0] mem_word_i,
  output logic [31:0] word_c_o
);

  logic [31:0] mem_w;
  logic [31:0] len_hi;
  logic [31:0] len_lo;
  logic        last_blk;

`ifdef SHA256_PAD_BYTESWAP_EN
  assign mem_w = {mem_word_i[7:0], mem_word_i[15:8], mem_word_i[23:16], mem_word_i[31:24]};
`else
  assign mem_w = mem_word_i;
`endif

  assign len_hi   = 32'(n_i) >> 27;
  assign len_lo   = 32'(n_i) << 5;
  assign last_blk = (b_i == nblk_i - 8'd1);

  always_comb begin
    word_c_o = '0;
    if (g_i < n_i) begin
      word_c_o = mem_w;
    end else if (g_i == n_i) begin
      word_c_o = SHA256_PAD_MARKER;
    end else if (last_blk && p_i == 4'd14) begin
      word_c_o = len_hi;
    end else if (last_blk && p_i == 4'd15) begin
      word_c_o = len_lo;
    end
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// Fetches a word-addressed message and emits SHA-256 padded 512-bit blocks.
// Build option SHA256_PAD_BYTESWAP_EN byte-reverses each fetched word.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter logic [15:0]  MAX_WORDS = 16'd1024,
  parameter int unsigned  ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       num_words,
  input  logic [ADDR_W-1:0] message_addr,
  output logic              busy,
  output logic              done,
  output logic              len_err,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_read_data,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [511:0]      blk_data,
  output logic              blk_last,
  output logic [7:0]        blk_idx
);

  pad_state_e          state_q;
  logic [15:0]         n_q;
  logic [7:0]          nblk_q;
  logic [ADDR_W-1:0]   base_q;
  logic                ovf_q;
  logic [7:0]          b_q;
  logic [4:0]          p_q;
  logic [15:0][31:0]   words_q;
  logic                busy_q, done_q, len_err_q, blk_valid_q, blk_last_q;
  logic [7:0]          blk_idx_q;
  logic [ADDR_W-1:0]   mem_addr_q;

  logic [15:0] n_clamp;
  logic [3:0]  p_sel;
  logic [15:0] g_sel, g_next, g_nb;
  logic [31:0] sel_word;

  assign n_clamp = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
  // Slot being written trails the read being issued by one cycle.
  assign p_sel   = 4'(p_q - 5'd1);
  assign g_sel   = 16'({b_q, p_sel});
  assign g_next  = 16'({b_q, 4'(p_q + 5'd1)});
  assign g_nb    = 16'({8'(b_q + 8'd1), 4'd0});

  sha256_pad_word_sel u_word_sel (
    .g_i        (g_sel),
    .n_i        (n_q),
    .b_i        (b_q),
    .nblk_i     (nblk_q),
    .p_i        (p_sel),
    .mem_word_i (mem_read_data),
    .word_c_o   (sel_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      n_q         <= '0;
      nblk_q      <= '0;
      base_q      <= '0;
      ovf_q       <= 1'b0;
      b_q         <= '0;
      p_q         <= '0;
      words_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      len_err_q   <= 1'b0;
      blk_valid_q <= 1'b0;
      blk_last_q  <= 1'b0;
      blk_idx_q   <= '0;
      mem_addr_q  <= '0;
    end else begin
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            n_q     <= n_clamp;
            nblk_q  <= 8'(sha256_num_blocks(n_clamp));
            base_q  <= message_addr;
            ovf_q   <= (num_words > MAX_WORDS);
            b_q     <= '0;
            p_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= FILL;
            if (n_clamp != 16'd0) mem_addr_q <= message_addr;
          end
        end
        FILL: begin
          if (p_q != 5'd0) words_q[4'd15 - p_sel] <= sel_word;
          if (p_q == 5'd16) begin
            state_q     <= PRESENT;
            blk_valid_q <= 1'b1;
            blk_last_q  <= (b_q == nblk_q - 8'd1);
            blk_idx_q   <= b_q;
          end else begin
            p_q <= p_q + 5'd1;
            if (p_q < 5'd15 && g_next < n_q) mem_addr_q <= base_q + ADDR_W'(g_next);
          end
        end
        PRESENT: begin
          if (blk_ready) begin
            blk_valid_q <= 1'b0;
            blk_last_q  <= 1'b0;
            blk_idx_q   <= '0;
            if (blk_last_q) begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              len_err_q <= ovf_q;
              busy_q    <= 1'b0;
            end else begin
              b_q     <= b_q + 8'd1;
              p_q     <= '0;
              state_q <= FILL;
              if (g_nb < n_q) mem_addr_q <= base_q + ADDR_W'(g_nb);
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign len_err   = len_err_q;
  assign mem_addr  = mem_addr_q;
  assign blk_valid = blk_valid_q;
  assign blk_data  = words_q;
  assign blk_last  = blk_last_q;
  assign blk_idx   = blk_idx_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder against a queue-based padding model.
module tb_sha256_msg_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [15:0]  num_words;
  logic [15:0]  message_addr;
  logic         busy, done, len_err;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_read_data;
  logic         blk_valid, blk_ready, blk_last;
  logic [511:0] blk_data;
  logic [7:0]   blk_idx;

  logic [31:0]  mem [0:65535];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_read_data <= mem[mem_addr];

  sha256_msg_padder dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .num_words     (num_words),
    .message_addr  (message_addr),
    .busy          (busy),
    .done          (done),
    .len_err       (len_err),
    .mem_addr      (mem_addr),
    .mem_read_data (mem_read_data),
    .blk_valid     (blk_valid),
    .blk_ready     (blk_ready),
    .blk_data      (blk_data),
    .blk_last      (blk_last),
    .blk_idx       (blk_idx)
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_mem(input logic [31:0] w);
`ifdef SHA256_PAD_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_lerr"},  len_err, 0);
    chk({tag, "_valid"}, blk_valid, 0);
    chk({tag, "_last"},  blk_last, 0);
    chk({tag, "_idx"},   blk_idx, 0);
    chk({tag, "_addr"},  mem_addr, 0);
    chk({tag, "_data"},  blk_data, 0);
  endtask

  // Pads the message as a word queue, then streams and checks every block.
  task automatic run_msg(input int nw, input logic [15:0] addr, input int stall0, input bit pulse);
    logic [31:0]  q[$];
    logic [63:0]  bl;
    logic [511:0] exp;
    int n, nblk, cnt, st;
    n = (nw > 1024) ? 1024 : nw;
    for (int i = 0; i < n; i++) q.push_back(model_mem(mem[16'(addr + 16'(i))]));
    q.push_back(32'h8000_0000);
    while (q.size() % 16 != 14) q.push_back(32'h0);
    bl = 64'(n) * 64'd32;
    q.push_back(bl[63:32]);
    q.push_back(bl[31:0]);
    nblk = q.size() / 16;

    @(negedge clk);
    start = 1'b1; num_words = 16'(nw); message_addr = addr;
    @(negedge clk);
    start = 1'b0; num_words = 16'($urandom); message_addr = 16'($urandom);
    chk("busy_after_start", busy, 1);
    cnt = 1;
    for (int b = 0; b < nblk; b++) begin
      while (!blk_valid && cnt < 100) begin
        blk_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        cnt++;
      end
      blk_ready = 1'b0;
      if (!blk_valid) begin
        chk("valid_timeout", blk_valid, 1);
        return;
      end
      chk("latency", 512'(cnt), 512'(18));
      for (int p = 0; p < 16; p++) exp[511 - 32*p -: 32] = q[16*b + p];
      chk("blk_data", blk_data, exp);
      chk("blk_idx", blk_idx, 512'(b));
      chk("blk_last", blk_last, (b == nblk - 1) ? 1 : 0);
      st = (stall0 >= 0 && b == 0) ? stall0 : int'($urandom_range(0, 3));
      for (int s = 0; s < st; s++) begin
        if (pulse && s == 1) begin
          start = 1'b1; num_words = 16'd3; message_addr = 16'h5000;
        end
        @(negedge clk);
        start = 1'b0;
        chk("stall_valid", blk_valid, 1);
        chk("stall_data", blk_data, exp);
      end
      blk_ready = 1'b1;
      @(negedge clk);
      blk_ready = 1'b0;
      cnt = 1;
      if (b == nblk - 1) begin
        chk("done_pulse", done, 1);
        chk("len_err", len_err, (nw > 1024) ? 1 : 0);
        chk("busy_at_done", busy, 0);
        @(negedge clk);
        chk("done_clear", done, 0);
      end else begin
        chk("valid_drop", blk_valid, 0);
      end
    end
  endtask

  initial begin
    int cnt;
    for (int a = 0; a < 65536; a++) mem[a] = $urandom;
    reset = 1'b1; start = 1'b0; num_words = '0; message_addr = '0; blk_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;

    for (int i = 0; i < 20; i++) mem[16'h0100 + i] = 32'(i);
    run_msg(20, 16'h0100, 0, 0);
    run_msg(13, 16'h0200, 0, 0);
    run_msg(14, 16'h0400, 2, 0);
    run_msg(0, 16'h0600, 0, 0);
    run_msg(20, 16'h0100, 7, 1);

    // Reset in the middle of filling block 1, then a fresh single-block run.
    @(negedge clk);
    start = 1'b1; num_words = 16'd20; message_addr = 16'h0100;
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    while (!blk_valid && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("rst_pre_valid", blk_valid, 1);
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_pre_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check_idle("rst_mid");
    reset = 1'b0;
    run_msg(13, 16'h0300, 0, 0);

    run_msg(1030, 16'hFFF0, 0, 0);
    run_msg(30, 16'hFFFA, -1, 0);

    for (int t = 0; t < 12; t++)
      run_msg(int'($urandom_range(0, 40)), 16'($urandom), -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Upstream stage of the SHA-256 hashing core.
- Reads a message of 32-bit words from the shared word-addressed memory and applies standard SHA-256 padding: a 0x80000000 marker word, zero fill, and a 64-bit big-endian bit length.
- Presents the result one 512-bit block at a time over a valid/ready handshake, for the compression FSM to consume.
- Removes all fetch and padding logic from the hash core.

Parameters:
- MAX_WORDS, 16'd1024: largest accepted num_words. Larger requests are clamped to MAX_WORDS and flagged.
- ADDR_W, 16: memory word-address width.

Ports:
- clk  in  1  sole clock; also drives the memory clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- num_words  in  16  message length in 32-bit words; latched on start.
- message_addr  in  ADDR_W  word address of message word 0; latched on start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last block's handshake.
- len_err  out  1  high with done if num_words > MAX_WORDS.
- mem_addr  out  ADDR_W  read address (read-only port; no write enable).
- mem_read_data  in  32  read data, valid exactly 1 cycle after mem_addr.
- blk_valid  out  1  blk_data holds a complete padded block.
- blk_ready  in  1  consumer accepts the block.
- blk_data  out  512  word 0 in [511:480], word 15 in [31:0].
- blk_last  out  1  final block of the message; qualified by blk_valid.
- blk_idx  out  8  0-based block number; qualified by blk_valid.

Behaviour:
- Reset (any time, mid-operation included): state IDLE.
  - All outputs 0: busy, done, len_err, blk_valid, blk_last, blk_idx, mem_addr, blk_data.
  - No partial block survives reset.
- Lengths:
  - n = min(num_words, MAX_WORDS).
  - nblk = (n+2)/16 + 1 (integer division).
  - Bit length L = n*32, as a 64-bit value: high word = n>>27, low word = n<<5.
- Word generator, global index g = 16*b + p, for block b and position p 0..15:
  - g < n: mem[message_addr+g].
  - g == n: 32'h80000000.
  - b == nblk-1 and p == 14: L high word.
  - b == nblk-1 and p == 15: L low word.
  - Otherwise: 0.
  - The length words take priority only in the last block; by construction they never collide with g ≤ n.
- States:
  - IDLE: start → latch inputs, busy=1, b=0 → FILL.
  - FILL: issue one read per cycle for p=0..15 whenever g<n, and write the returned word into slot p-1 the following cycle. Non-memory slots are written directly. After 17 FILL cycles → PRESENT.
  - PRESENT: blk_valid=1; blk_data, blk_last and blk_idx held stable while blk_ready=0.
    - On blk_valid&&blk_ready, if not last: b++ → FILL.
    - On blk_valid&&blk_ready, if last: → DONE.
  - DONE: done=1 for 1 cycle, busy=0 → IDLE.
- Latency: blk_valid rises exactly 18 cycles after the start cycle, and exactly 18 cycles after each non-final handshake.
- The handshake is the cycle where blk_valid&&blk_ready are both 1. blk_ready while blk_valid=0 is ignored.
- start while busy is ignored; inputs are not re-latched.
- mem_addr holds its last value when no read is issued.
- Address arithmetic wraps modulo 2^ADDR_W.
- n == 0 is legal and produces one block: word 0 = 0x80000000, all others 0.

Optional Feature:
- Macro: SHA256_PAD_BYTESWAP_EN.
- Defined: each mem_read_data word is byte-reversed ({b0,b1,b2,b3}) before it is placed in the block. Marker and length words are not swapped.
- Undefined: memory words pass through unchanged.
- Timing is identical in both builds.

Decomposition:
- Package sha256_pkg holds:
  - typedef sha256_block_t (logic [511:0]);
  - typedef pad_state_e (IDLE, FILL, PRESENT, DONE);
  - constant SHA256_PAD_MARKER = 32'h80000000;
  - function sha256_num_blocks(n).
- Sub-module sha256_pad_word_sel: combinational selection of one padded word from (g, n, b, nblk, p, mem word). It is shared with the hash core's tests.

Test Plan:
- n=20, memory words = index, message_addr=0x0100 → 2 blocks.
  - Block 0 = words 0..15.
  - Block 1: words 16..19, word 4 = 0x80000000, words 14/15 = 0x00000000 / 0x00000280; blk_last only on block 1.
- n=13 → 1 block: word 13 = 0x80000000, word 14 = 0, word 15 = 0x000001A0.
- n=14 → 2 blocks: block 0 word 14 = 0x80000000, word 15 = 0; block 1 all zero except word 15 = 0x000001C0.
- n=0 → 1 block: word 0 = 0x80000000, rest 0; done 1 cycle after the handshake.
- n=20 with blk_ready held low 7 cycles → blk_data stable throughout; a start pulse issued meanwhile is ignored; second blk_valid 18 cycles after the first handshake.
- Reset asserted in FILL of block 1 → all outputs 0 next edge; a fresh start with n=13 yields a correct single block.
